// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if: datapath-to-data-memory bus plus store-buffer status and perf counters
interface dmem_store_buffer_if #(parameter int SB_DEPTH = 4);
  logic [63:0] memAddr, memWriteData, memReadData;
  logic MemWrite, MemRead, sb_full, addr_err;
  logic [$clog2(SB_DEPTH):0] sb_count;
  logic [31:0] rd_cnt, wr_cnt, fwd_cnt;
  modport master (
    output memAddr, memWriteData, MemWrite, MemRead,
    input memReadData, sb_count, sb_full, addr_err, rd_cnt, wr_cnt, fwd_cnt
  );
  modport slave (
    input memAddr, memWriteData, MemWrite, MemRead,
    output memReadData, sb_count, sb_full, addr_err, rd_cnt, wr_cnt, fwd_cnt
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-store FIFO in front of a word array, forwarding loads; DMEM_PERF_CNT_EN adds perf counters
module dmem_store_buffer #(
  parameter int DEPTH = 1024,
  parameter int SB_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dmem_store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;
  state_t state;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] sb_idx [SB_DEPTH];
  logic [63:0] sb_data [SB_DEPTH];
  logic [PW-1:0] head, tail, p;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] idx;
  logic [63:0] fwd;
  logic legal, push, drain, hit, addr_err;
  assign idx = bus.memAddr[3 +: AW];
  assign legal = bus.memAddr[2:0] == 3'd0 && (bus.memAddr >> 3) < 64'(DEPTH);
  assign push = bus.MemWrite && legal;
  assign drain = count != '0 && (!bus.MemRead || state == FULL);
  assign count_n = count + CW'(push) - CW'(drain);
  assign bus.sb_count = count;
  assign bus.sb_full = state == FULL;
  assign bus.addr_err = addr_err;
  assign bus.memReadData = bus.MemRead && legal ? (hit ? fwd : mem[idx]) : '0;
  // scan oldest to youngest so the last match is the youngest entry
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    p = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      p = head + PW'(i);
      if (CW'(i) < count && sb_idx[p] == idx) begin
        hit = 1'b1;
        fwd = sb_data[p];
      end
    end
  end
  // pointers, occupancy, drain FSM and sticky address error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head <= '0;
      tail <= '0;
      count <= '0;
      addr_err <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      count <= count_n;
      state <= count_n == '0 ? EMPTY : count_n == CW'(SB_DEPTH) ? FULL : HOLD;
      if ((bus.MemRead || bus.MemWrite) && !legal) addr_err <= 1'b1;
    end
  end
  // buffer payload and array contents survive reset
  always_ff @(posedge clk) begin
    if (push) begin
      sb_idx[tail] <= idx;
      sb_data[tail] <= bus.memWriteData;
    end
    if (drain) mem[sb_idx[head]] <= sb_data[head];
  end
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt, wr_cnt, fwd_cnt;
  // legal loads, legal stores, and loads satisfied by forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      fwd_cnt <= '0;
    end else begin
      if (bus.MemRead && legal) rd_cnt <= rd_cnt + 32'd1;
      if (push) wr_cnt <= wr_cnt + 32'd1;
      if (bus.MemRead && legal && hit) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
  assign bus.rd_cnt = rd_cnt;
  assign bus.wr_cnt = wr_cnt;
  assign bus.fwd_cnt = fwd_cnt;
`else
  assign bus.rd_cnt = '0;
  assign bus.wr_cnt = '0;
  assign bus.fwd_cnt = '0;
`endif
endmodule
